// File: rtl/lfo_rate_controller.sv
// Rate/peak controller for the modulation triangle LFO: prescaled step strobe plus
// glitch-free reconfiguration at wave-cycle boundaries. Optional tap-tempo sync: LFO_RATE_CTRL_SYNC_EN.
module lfo_rate_controller #(
  parameter int DATA_WIDTH    = 8,
  parameter int DIV_WIDTH     = 16,
  parameter int DEFAULT_LIMIT = 30,
  parameter int DEFAULT_DIV   = 1000
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [DATA_WIDTH-1:0] cfg_limit,
  input  logic                  dir_in,
`ifdef LFO_RATE_CTRL_SYNC_EN
  input  logic                  sync_in,
  output logic                  gen_clear,
`endif
  output logic                  step_en,
  output logic [DATA_WIDTH-1:0] limit,
  output logic [DIV_WIDTH-1:0]  cur_div,
  output logic                  cycle_done,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [DIV_WIDTH-1:0]  DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] LIM_ONE   = DATA_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0]  DEF_DIV   = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DATA_WIDTH-1:0] DEF_LIMIT = DATA_WIDTH'(DEFAULT_LIMIT);

  logic [1:0]            state_q, state_d;
  logic [DIV_WIDTH-1:0]  presc_q, presc_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DATA_WIDTH-1:0] limit_q, limit_d;
  logic [DIV_WIDTH-1:0]  pend_div_q, pend_div_d;
  logic [DATA_WIDTH-1:0] pend_limit_q, pend_limit_d;
  logic                  cycle_done_q, cycle_done_d;
  logic                  dir_prev_q;

  logic                  running;
  logic                  cfg_acc;
  logic                  sync_hit;
  logic                  boundary;
  logic                  presc_at_end;
  logic [DIV_WIDTH-1:0]  presc_nxt;
  logic [DIV_WIDTH-1:0]  cfg_div_s;
  logic [DATA_WIDTH-1:0] cfg_limit_s;

`ifdef LFO_RATE_CTRL_SYNC_EN
  logic gen_clear_q, gen_clear_d;
  assign sync_hit  = sync_in;
  assign gen_clear = gen_clear_q;
`else
  assign sync_hit  = 1'b0;
`endif

  assign running      = (state_q != ST_IDLE);
  assign cfg_ready    = (state_q != ST_PEND);
  assign busy         = (state_q == ST_PEND);
  assign cfg_acc      = cfg_valid & cfg_ready;
  assign presc_at_end = (presc_q == div_q - DIV_ONE);
  assign presc_nxt    = presc_at_end ? '0 : presc_q + DIV_ONE;
  // A sync restart is treated exactly like the generator returning to zero.
  assign boundary     = (dir_prev_q & ~dir_in) | sync_hit;

  // Zero divider/peak would stall the generator, so clamp them to one.
  assign cfg_div_s   = (cfg_div == '0) ? DIV_ONE : cfg_div;
  assign cfg_limit_s = (cfg_limit == '0) ? LIM_ONE : cfg_limit;

  assign step_en    = running & enable & presc_at_end;
  assign limit      = limit_q;
  assign cur_div    = div_q;
  assign cycle_done = cycle_done_q;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    div_d        = div_q;
    limit_d      = limit_q;
    pend_div_d   = pend_div_q;
    pend_limit_d = pend_limit_q;
    cycle_done_d = 1'b0;
`ifdef LFO_RATE_CTRL_SYNC_EN
    gen_clear_d  = sync_hit & enable & running;
`endif
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (cfg_acc) begin
          div_d   = cfg_div_s;
          limit_d = cfg_limit_s;
        end
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        presc_d      = sync_hit ? '0 : presc_nxt;
        cycle_done_d = boundary;
        if (!enable) begin
          state_d = ST_IDLE;
          presc_d = '0;
          if (cfg_acc) begin
            div_d   = cfg_div_s;
            limit_d = cfg_limit_s;
          end
        end else if (cfg_acc) begin
          pend_div_d   = cfg_div_s;
          pend_limit_d = cfg_limit_s;
          state_d      = ST_PEND;
        end
      end
      ST_PEND: begin
        presc_d      = presc_nxt;
        cycle_done_d = boundary;
        if (boundary || !enable) begin
          div_d   = pend_div_q;
          limit_d = pend_limit_q;
          presc_d = '0;
          state_d = enable ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      div_q        <= DEF_DIV;
      limit_q      <= DEF_LIMIT;
      pend_div_q   <= '0;
      pend_limit_q <= '0;
      cycle_done_q <= 1'b0;
      dir_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      div_q        <= div_d;
      limit_q      <= limit_d;
      pend_div_q   <= pend_div_d;
      pend_limit_q <= pend_limit_d;
      cycle_done_q <= cycle_done_d;
      dir_prev_q   <= dir_in;
    end
  end

`ifdef LFO_RATE_CTRL_SYNC_EN
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) gen_clear_q <= 1'b0;
    else     gen_clear_q <= gen_clear_d;
  end
`endif

endmodule

// File: tb/tb_lfo_rate_controller.sv
// Directed bench for lfo_rate_controller; step_en timing is scored against a queue
// of expected strobe cycles pushed as each stimulus phase starts.
module tb_lfo_rate_controller;
  localparam int DW = 8;
  localparam int VW = 16;

  logic          CLK = 1'b0;
  logic          rst;
  logic          enable;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [VW-1:0] cfg_div;
  logic [DW-1:0] cfg_limit;
  logic          dir_in;
  logic          step_en;
  logic [DW-1:0] limit;
  logic [VW-1:0] cur_div;
  logic          cycle_done;
  logic          busy;
`ifdef LFO_RATE_CTRL_SYNC_EN
  logic          sync_in;
  logic          gen_clear;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_q[$];

  always #5 CLK = ~CLK;

  lfo_rate_controller #(
    .DATA_WIDTH(DW), .DIV_WIDTH(VW), .DEFAULT_LIMIT(30), .DEFAULT_DIV(1000)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .enable(enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div(cfg_div),
    .cfg_limit(cfg_limit),
    .dir_in(dir_in),
`ifdef LFO_RATE_CTRL_SYNC_EN
    .sync_in(sync_in),
    .gen_clear(gen_clear),
`endif
    .step_en(step_en),
    .limit(limit),
    .cur_div(cur_div),
    .cycle_done(cycle_done),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock, sampled on the falling edge; any step_en is scored against the queue.
  task automatic step_cycle();
    int want;
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    if (step_en) begin
      want = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      check("step_at_cycle", 32'(cyc), 32'(want));
    end else if (exp_q.size() != 0 && exp_q[0] <= cyc) begin
      check("step_missing", 32'(step_en), 32'd1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic push_steps(input int first, input int period, input int count);
    for (int k = 0; k < count; k++) exp_q.push_back(first + k * period);
  endtask

  int e;
  int t;

  initial begin
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_limit = '0; dir_in = 1'b0;
`ifdef LFO_RATE_CTRL_SYNC_EN
    sync_in = 1'b0;
`endif
    step_cycle();
    step_cycle();
    check("rst_step_en", 32'(step_en), 32'd0);
    check("rst_limit", 32'(limit), 32'd30);
    check("rst_cur_div", 32'(cur_div), 32'd1000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_cycle_done", 32'(cycle_done), 32'd0);
`ifdef LFO_RATE_CTRL_SYNC_EN
    check("rst_gen_clear", 32'(gen_clear), 32'd0);
`endif
    rst = 1'b0;
    step_cycle();

    // Default rate: strobe every 1000 cycles after enable.
    enable = 1'b1;
    e = cyc;
    push_steps(e + 1000, 1000, 3);
    repeat (3000) step_cycle();
    check("default_queue", 32'(exp_q.size()), 32'd0);
    check("default_limit", 32'(limit), 32'd30);
    enable = 1'b0;
    #1;
    check("enable_low_gates_step", 32'(step_en), 32'd0);
    step_cycle();

    // IDLE configuration applies on the next edge.
    cfg_div = 16'd4; cfg_limit = 8'd10; cfg_valid = 1'b1;
    #1;
    check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    step_cycle();
    cfg_valid = 1'b0;
    check("idle_limit", 32'(limit), 32'd10);
    check("idle_cur_div", 32'(cur_div), 32'd4);
    check("idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    e = cyc;
    push_steps(e + 4, 4, 3);
    repeat (12) step_cycle();

    // RUN reconfiguration waits for the dir_in falling edge.
    cfg_div = 16'd2; cfg_limit = 8'd5; cfg_valid = 1'b1;
    push_steps(e + 16, 4, 1);
    step_cycle();
    cfg_valid = 1'b0;
    check("pend_cfg_ready", 32'(cfg_ready), 32'd0);
    check("pend_busy", 32'(busy), 32'd1);
    check("pend_old_limit", 32'(limit), 32'd10);
    check("pend_old_div", 32'(cur_div), 32'd4);
    dir_in = 1'b1;
    repeat (4) step_cycle();
    check("pend_no_boundary", 32'(cycle_done), 32'd0);
    dir_in = 1'b0;
    step_cycle();
    check("bnd_cycle_done", 32'(cycle_done), 32'd1);
    check("bnd_limit", 32'(limit), 32'd5);
    check("bnd_cur_div", 32'(cur_div), 32'd2);
    check("bnd_busy", 32'(busy), 32'd0);
    check("bnd_cfg_ready", 32'(cfg_ready), 32'd1);
    push_steps(cyc + 1, 2, 3);
    step_cycle();
    check("bnd_cycle_done_single", 32'(cycle_done), 32'd0);
    repeat (4) step_cycle();

    // Zero config clamps to 1; dropping enable in PENDING applies it.
    t = cyc;
    cfg_div = 16'd0; cfg_limit = 8'd0; cfg_valid = 1'b1;
    push_steps(t + 2, 2, 1);
    step_cycle();
    cfg_valid = 1'b0;
    check("zero_pend_busy", 32'(busy), 32'd1);
    check("zero_pend_div", 32'(cur_div), 32'd2);
    step_cycle();
    enable = 1'b0;
    #1;
    check("pend_enable_low_step", 32'(step_en), 32'd0);
    step_cycle();
    check("drop_cur_div", 32'(cur_div), 32'd1);
    check("drop_limit", 32'(limit), 32'd1);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_cfg_ready", 32'(cfg_ready), 32'd1);
    check("drop_step_en", 32'(step_en), 32'd0);
    step_cycle();
    check("idle_div1_no_step", 32'(step_en), 32'd0);
    enable = 1'b1;
    e = cyc;
    push_steps(e + 1, 1, 6);
    repeat (5) step_cycle();
    cfg_div = 16'd7; cfg_limit = 8'd9; cfg_valid = 1'b1;
    step_cycle();
    cfg_valid = 1'b0;
    check("div1_pend_busy", 32'(busy), 32'd1);

    // Asynchronous reset mid-run discards the pending configuration.
    rst = 1'b1;
    #1;
    check("arst_step_en", 32'(step_en), 32'd0);
    check("arst_cycle_done", 32'(cycle_done), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("arst_limit", 32'(limit), 32'd30);
    check("arst_cur_div", 32'(cur_div), 32'd1000);
    check("arst_queue", 32'(exp_q.size()), 32'd0);
    enable = 1'b0;
    step_cycle();
    rst = 1'b0;
    dir_in = 1'b1;
    step_cycle();
    dir_in = 1'b0;
    step_cycle();
    check("idle_no_cycle_done", 32'(cycle_done), 32'd0);
    step_cycle();
    check("post_rst_cur_div", 32'(cur_div), 32'd1000);
    check("post_rst_limit", 32'(limit), 32'd30);
    check("post_rst_busy", 32'(busy), 32'd0);

`ifdef LFO_RATE_CTRL_SYNC_EN
    // Sync two cycles into a 4-cycle period restarts the prescaler.
    cfg_div = 16'd4; cfg_limit = 8'd10; cfg_valid = 1'b1;
    step_cycle();
    cfg_valid = 1'b0;
    enable = 1'b1;
    e = cyc;
    repeat (2) step_cycle();
    sync_in = 1'b1;
    step_cycle();
    sync_in = 1'b0;
    check("sync_gen_clear", 32'(gen_clear), 32'd1);
    push_steps(e + 6, 4, 2);
    step_cycle();
    check("sync_gen_clear_single", 32'(gen_clear), 32'd0);
    repeat (6) step_cycle();
`endif

    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfo_rate_controller.md
Name: lfo_rate_controller

Overview:
- Controller for the triangle LFO generator used by the modulation effects (tremolo/vibrato).
- Produces a step-enable strobe that sets the LFO rate, and drives the runtime peak (upper limit) of the generator.
- Accepts rate/peak reconfiguration through a valid/ready handshake. In RUN, new settings take effect only at a wave cycle boundary so the audio path never sees a discontinuity.
- Sits between the effect control registers and the enabled, runtime-limit triangle generator; observes the generator's direction flag.

Parameters:
DATA_WIDTH, 8, width of the wave and limit values
DIV_WIDTH, 16, width of the rate prescaler and divider value
DEFAULT_LIMIT, 30, peak value loaded at reset
DEFAULT_DIV, 1000, CLK cycles per wave step loaded at reset

Ports:
CLK  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  run request; low freezes the LFO
cfg_valid  input  1  new configuration offered
cfg_ready  output  1  controller can accept configuration
cfg_div  input  DIV_WIDTH  requested CLK cycles per step
cfg_limit  input  DATA_WIDTH  requested wave peak
dir_in  input  1  generator direction (0 = up, 1 = down)
step_en  output  1  one-cycle strobe: generator advances one step
limit  output  DATA_WIDTH  active peak driven to generator
cur_div  output  DIV_WIDTH  active divider
cycle_done  output  1  one-cycle pulse at each wave cycle boundary
busy  output  1  configuration accepted but not yet applied

Behaviour:
- Interface: one clock (CLK); rst is asynchronous and active-high. All state is updated on the rising edge of CLK, or immediately when rst is asserted.
- Reset values:
  - state = IDLE, prescaler = 0
  - step_en = 0, cycle_done = 0, busy = 0, cfg_ready = 1
  - limit = DEFAULT_LIMIT, cur_div = DEFAULT_DIV
  - pending registers cleared
- States: IDLE, RUN, PENDING.
- IDLE:
  - step_en held 0; prescaler held at 0.
  - Config accepted (cfg_valid & cfg_ready) is applied on the next edge: limit and cur_div update; busy stays 0.
  - enable = 1 -> RUN.
- RUN:
  - Prescaler counts 0 .. cur_div-1 and wraps.
  - step_en = 1 for exactly one cycle when the prescaler equals cur_div-1.
  - An accepted config is captured in pending registers -> PENDING; busy = 1 and cfg_ready = 0 from the next cycle.
- PENDING:
  - Stepping continues with the old values.
  - On a cycle boundary: limit and cur_div load the pending values, prescaler clears to 0, busy drops -> RUN.
- Cycle boundary:
  - Defined as a falling edge of dir_in (registered previous value 1, current value 0), i.e. the generator has returned to 0 and turned up.
  - cycle_done pulses for one cycle, registered one cycle after the edge is sampled, in RUN and PENDING.
- Rate timing: first step_en comes cur_div cycles after entering RUN, then every cur_div cycles.
- Width rules:
  - cfg_div = 0 is stored as 1, giving step_en every cycle.
  - cfg_limit = 0 is stored as 1.
  - Prescaler compare uses full DIV_WIDTH; no overflow is possible.
- enable low in RUN or PENDING:
  - -> IDLE on the next edge; step_en = 0 that cycle; prescaler cleared.
  - A pending config is applied on the same edge; busy = 0.
- Simultaneous events:
  - cfg accept and enable falling in the same cycle: -> IDLE with the new config applied.
  - cfg accept and cycle boundary in RUN: the config goes to PENDING and waits for the next boundary.
- cfg_ready = 1 in IDLE and RUN, and 0 in PENDING.
- rst mid-operation: immediate return to reset values; the pending config is discarded.

Optional Feature:
- Macro: LFO_RATE_CTRL_SYNC_EN (tap-tempo sync).
- Defined:
  - Adds input sync_in (1 bit) and output gen_clear (1 bit, reset 0).
  - A sync_in high in RUN or PENDING clears the prescaler and pulses gen_clear for one cycle; the generator restarts from 0, going up.
  - A pending config is applied on the same edge, which counts as a cycle boundary: cycle_done pulses.
  - sync_in is ignored in IDLE.
- Undefined: neither port exists; behaviour is exactly as above.

Test Plan:
- Reset, enable = 1, no config -> first step_en at cycle 1000 after enable, then every 1000 cycles; limit = 30.
- In IDLE, cfg_div = 4, cfg_limit = 10, valid = 1 -> accepted in 1 cycle; limit = 10, cur_div = 4 next edge; after enable, step_en every 4 cycles.
- In RUN (div 4), offer div 2 / limit 5 -> cfg_ready drops, busy = 1; old rate until dir_in falls 1->0; then limit = 5, step_en every 2 cycles, cycle_done pulses once, busy = 0.
- cfg_div = 0, cfg_limit = 0 -> cur_div = 1, limit = 1; step_en asserted every cycle in RUN.
- Drop enable while PENDING -> IDLE next edge, step_en = 0, pending values applied, busy = 0; assert rst mid-RUN -> all outputs at reset values immediately.
- (SYNC_EN) sync_in pulse 2 cycles into a 4-cycle period -> gen_clear pulses once, next step_en exactly 4 cycles after sync.
